// File: rtl/ser_key_pkg.sv
// Shared types and the LFSR step function for the serial key sequencer.
package ser_key_pkg;

    localparam int unsigned LfsrMaxW = 64;

    typedef enum logic [3:0] {
        CmdStep   = 4'h2,
        CmdReseed = 4'h8,
        CmdKey0   = 4'h9,
        CmdKey1   = 4'hA,
        CmdLock   = 4'hC
    } cmd_e;

    typedef enum logic [1:0] {
        StLocked = 2'd0,
        StKeying = 2'd1,
        StOpen   = 2'd2
    } fsm_e;

    // Narrower LFSRs pass zero-extended state and poly; the upper bits stay zero.
    function automatic logic [LfsrMaxW-1:0] lfsr_next(input logic [LfsrMaxW-1:0] s,
                                                     input logic [LfsrMaxW-1:0] poly);
        return (s >> 1) ^ (s[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/ser_key_lfsr.sv
// Galois LFSR state register plus the step counter since the last reseed.
module ser_key_lfsr
    import ser_key_pkg::*;
#(
    parameter int unsigned         STATE_W = 16,
    parameter logic [STATE_W-1:0] POLY    = 16'hB400,
    parameter logic [STATE_W-1:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step_i,
    input  logic               reseed_i,
    output logic [STATE_W-1:0] state_o,
    output logic [7:0]         seq_cnt_o
);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [7:0]          seq_cnt_q, seq_cnt_d;
    logic [LfsrMaxW-1:0] state_nxt;

    assign state_nxt = lfsr_next(LfsrMaxW'(state_q), LfsrMaxW'(POLY));

    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        if (reseed_i) begin
            state_d   = SEED;
            seq_cnt_d = 8'd0;
        end else if (step_i) begin
            state_d   = state_nxt[STATE_W-1:0];
            seq_cnt_d = seq_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SEED;
            seq_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            seq_cnt_q <= seq_cnt_d;
        end
    end

    assign state_o   = state_q;
    assign seq_cnt_o = seq_cnt_q;

    logic [LfsrMaxW-1:0] unused_nxt;
    assign unused_nxt = state_nxt;

endmodule

// File: rtl/ser_key_seq.sv
// Bus-mapped serial key sequencer: address decode, key FSM, masked LFSR response.
// Key locking is built only when SER_KEY_LOCK_EN is defined; otherwise always open.
module ser_key_seq
    import ser_key_pkg::*;
#(
    parameter int unsigned         STATE_W  = 16,
    parameter logic [STATE_W-1:0] POLY     = 16'hB400,
    parameter logic [STATE_W-1:0] SEED     = 16'hACE1,
    parameter int unsigned         CHANNELS = 2,
    parameter logic [3:0]          WINDOW   = 4'h1,
    parameter int unsigned         KEY_W    = 8,
    parameter logic [KEY_W-1:0]    KEY      = 8'h5A
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sser_n,
    input  logic [15:0]         ba,
    input  logic                br_w,
    input  logic                bstb,
    output logic [CHANNELS-1:0] sdrd,
    output logic                sdrd_oe,
    output logic                locked,
    output logic [7:0]          seq_cnt
);

    if (SEED == '0) begin : g_seed_chk
        $error("ser_key_seq: SEED must be nonzero");
    end
    if (STATE_W < KEY_W || STATE_W < CHANNELS || KEY_W < 2) begin : g_width_chk
        $error("ser_key_seq: need STATE_W >= KEY_W, STATE_W >= CHANNELS, KEY_W >= 2");
    end

    logic               hit;
    logic [3:0]         cmd;
    logic               is_open;
    logic [STATE_W-1:0] state;

    assign hit = bstb & ~sser_n & br_w & (ba[15:12] == WINDOW);
    assign cmd = ba[7:4];

    ser_key_lfsr #(
        .STATE_W(STATE_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_i   (hit & is_open & (cmd == CmdStep)),
        .reseed_i (hit & is_open & (cmd == CmdReseed)),
        .state_o  (state),
        .seq_cnt_o(seq_cnt)
    );

`ifdef SER_KEY_LOCK_EN
    localparam int unsigned CntW = $clog2(KEY_W + 1);

    fsm_e             fsm_q, fsm_d;
    logic [KEY_W-1:0] key_sr_q, key_sr_d, key_sr_shift;
    logic [CntW-1:0]  key_cnt_q, key_cnt_d, key_cnt_inc;
    logic             is_key, is_abort;

    assign is_key       = hit & ((cmd == CmdKey0) | (cmd == CmdKey1));
    assign is_abort     = hit & ((cmd == CmdStep) | (cmd == CmdReseed) | (cmd == CmdLock));
    assign key_sr_shift = {key_sr_q[KEY_W-2:0], cmd == CmdKey1};
    assign key_cnt_inc  = key_cnt_q + CntW'(1);

    always_comb begin
        fsm_d     = fsm_q;
        key_sr_d  = key_sr_q;
        key_cnt_d = key_cnt_q;
        case (fsm_q)
            StLocked: begin
                if (is_key) begin
                    fsm_d     = StKeying;
                    key_sr_d  = key_sr_shift;
                    key_cnt_d = key_cnt_inc;
                end
            end
            StKeying: begin
                if (is_key && key_cnt_inc == CntW'(KEY_W)) begin
                    fsm_d     = (key_sr_shift == KEY) ? StOpen : StLocked;
                    key_sr_d  = '0;
                    key_cnt_d = '0;
                end else if (is_key) begin
                    key_sr_d  = key_sr_shift;
                    key_cnt_d = key_cnt_inc;
                end else if (is_abort) begin
                    fsm_d     = StLocked;
                    key_sr_d  = '0;
                    key_cnt_d = '0;
                end
            end
            StOpen: begin
                if (hit && cmd == CmdLock) fsm_d = StLocked;
            end
            default: begin
                fsm_d     = StLocked;
                key_sr_d  = '0;
                key_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q     <= StLocked;
            key_sr_q  <= '0;
            key_cnt_q <= '0;
        end else begin
            fsm_q     <= fsm_d;
            key_sr_q  <= key_sr_d;
            key_cnt_q <= key_cnt_d;
        end
    end

    assign is_open = (fsm_q == StOpen);
`else
    assign is_open = 1'b1;

    logic unused_key;
    assign unused_key = ^KEY;
`endif

    assign locked  = ~is_open;
    assign sdrd_oe = hit;
    assign sdrd    = is_open ? state[CHANNELS-1:0] : '0;

    logic unused_bits;
    assign unused_bits = ^{ba[11:8], ba[3:0], state};

endmodule
